// File: rtl/sweep_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_analyzer_pkg
// Description : Shared FSM encoding and -3 dB ratio constants (181/128).
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    // 181/128 = 1.4141, so p2p*181 >= ref*128 tests p2p >= 0.7071*ref
    localparam int unsigned c_RATIO_NUM = 181;
    localparam int unsigned c_RATIO_DEN = 128;

endpackage
`default_nettype wire

// File: rtl/running_extremes.sv
`default_nettype none
// ============================================================================
// Module      : running_extremes
// Description : Signed running maximum/minimum registers with init/update.
// Revision    : 1.0 - initial release
// ============================================================================
module running_extremes #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_init,
    input  logic                  i_update,
    input  logic [DATA_WIDTH-1:0] i_sample,
    output logic [DATA_WIDTH-1:0] o_maximum_next,
    output logic [DATA_WIDTH-1:0] o_minimum_next
);

    logic signed [DATA_WIDTH-1:0] r_maximum;
    logic signed [DATA_WIDTH-1:0] r_minimum;

    // Next values include the current sample so the final window sample can be reported without a pipeline stage
    always_comb begin
        o_maximum_next = r_maximum;
        o_minimum_next = r_minimum;
        if (i_init) begin
            o_maximum_next = i_sample;
            o_minimum_next = i_sample;
        end else begin
            if ($signed(i_sample) > r_maximum) o_maximum_next = i_sample;
            if ($signed(i_sample) < r_minimum) o_minimum_next = i_sample;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_maximum <= '0;
            r_minimum <= '0;
        end else if (i_update) begin
            r_maximum <= o_maximum_next;
            r_minimum <= o_minimum_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sweep_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : sweep_response_analyzer
// Description : Settle/measure window over filter output; reports extremes,
//               peak-to-peak and passband (-3 dB) status against a reference.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_response_analyzer
    import sweep_analyzer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 100,
    parameter int WINDOW_CYCLES = 400
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  set_reference,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] maximum,
    output logic [DATA_WIDTH-1:0] minimum,
    output logic [DATA_WIDTH:0]   peak_to_peak,
    output logic                  in_passband
);

    localparam int              c_PROD_W      = DATA_WIDTH + 9;
    localparam logic [15:0]     c_SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [15:0]     c_WINDOW_LAST = 16'(WINDOW_CYCLES - 1);
    localparam logic [c_PROD_W-1:0] c_NUM     = c_PROD_W'(c_RATIO_NUM);
    localparam logic [c_PROD_W-1:0] c_DEN     = c_PROD_W'(c_RATIO_DEN);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_count;
    logic                    r_set_ref;
    logic [DATA_WIDTH:0]     r_reference;
    logic                    r_busy;
    logic                    r_result_valid;
    logic [DATA_WIDTH-1:0]   r_maximum;
    logic [DATA_WIDTH-1:0]   r_minimum;
    logic [DATA_WIDTH:0]     r_peak_to_peak;
    logic                    r_in_passband;

    logic                    w_accept;
    logic                    w_init;
    logic                    w_update;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_maximum_next;
    logic [DATA_WIDTH-1:0]   w_minimum_next;
    logic [DATA_WIDTH:0]     w_p2p;
    logic [c_PROD_W-1:0]     w_lhs;
    logic [c_PROD_W-1:0]     w_rhs;
    logic                    w_above;

    running_extremes #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extremes (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_init         (w_init),
        .i_update       (w_update),
        .i_sample       (data),
        .o_maximum_next (w_maximum_next),
        .o_minimum_next (w_minimum_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_init       = 1'b0;
        w_update     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (SETTLE_CYCLES == 0) ? ST_MEASURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_count == c_SETTLE_LAST) w_state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                w_update = 1'b1;
                w_init   = (r_count == 16'd0);
                if (r_count == c_WINDOW_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Counter restarts on every state change so each phase counts from zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                          r_count <= '0;
        else if (w_state_next != r_state || r_state == ST_IDLE) r_count <= '0;
        else                                                   r_count <= r_count + 16'd1;
    end

    // Sign-extend before subtracting so a full-scale swing cannot wrap
    assign w_p2p   = {w_maximum_next[DATA_WIDTH-1], w_maximum_next}
                   - {w_minimum_next[DATA_WIDTH-1], w_minimum_next};
    assign w_lhs   = c_PROD_W'(w_p2p) * c_NUM;
    assign w_rhs   = c_PROD_W'(r_reference) * c_DEN;
    assign w_above = (w_lhs >= w_rhs);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_set_ref      <= 1'b0;
            r_reference    <= '0;
            r_maximum      <= '0;
            r_minimum      <= '0;
            r_peak_to_peak <= '0;
            r_in_passband  <= 1'b0;
        end else begin
            r_busy         <= (w_state_next != ST_IDLE);
            r_result_valid <= w_last;
            if (w_accept) r_set_ref <= set_reference;
            if (w_last) begin
                r_maximum      <= w_maximum_next;
                r_minimum      <= w_minimum_next;
                r_peak_to_peak <= w_p2p;
                r_in_passband  <= r_set_ref | w_above;
                if (r_set_ref) r_reference <= w_p2p;
            end
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign maximum      = r_maximum;
    assign minimum      = r_minimum;
    assign peak_to_peak = r_peak_to_peak;
    assign in_passband  = r_in_passband;

endmodule
`default_nettype wire

// File: tb/tb_sweep_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_response_analyzer
// Description : Directed scoreboard bench for sweep_response_analyzer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_response_analyzer;

    localparam int DW = 32;
    localparam int S  = 4;
    localparam int W  = 8;

    typedef logic [DW-1:0] win_t [W];
    typedef struct packed {
        logic [DW-1:0] mx;
        logic [DW-1:0] mn;
        logic [DW:0]   p2p;
        logic          pb;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, set_reference;
    logic [DW-1:0] data;
    logic          busy, result_valid, in_passband;
    logic [DW-1:0] maximum, minimum;
    logic [DW:0]   peak_to_peak;

    logic          start2, set_ref2;
    logic [DW-1:0] data2;
    logic          busy2, valid2, pb2;
    logic [DW-1:0] max2, min2;
    logic [DW:0]   p2p2;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_valid  = 0;
    longint ref_model = 0;

    always #5 clock = ~clock;

    sweep_response_analyzer #(
        .DATA_WIDTH (DW), .SETTLE_CYCLES (S), .WINDOW_CYCLES (W)
    ) u_dut (
        .clock (clock), .reset_n (reset_n), .start (start),
        .set_reference (set_reference), .data (data), .busy (busy),
        .result_valid (result_valid), .maximum (maximum), .minimum (minimum),
        .peak_to_peak (peak_to_peak), .in_passband (in_passband)
    );

    sweep_response_analyzer #(
        .DATA_WIDTH (DW), .SETTLE_CYCLES (0), .WINDOW_CYCLES (1)
    ) u_dut_short (
        .clock (clock), .reset_n (reset_n), .start (start2),
        .set_reference (set_ref2), .data (data2), .busy (busy2),
        .result_valid (valid2), .maximum (max2), .minimum (min2),
        .peak_to_peak (p2p2), .in_passband (pb2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard side: every result pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n === 1'b1 && result_valid === 1'b1) begin
            exp_t e;
            n_valid++;
            chk("result_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("maximum",      64'(maximum),      64'(e.mx));
                chk("minimum",      64'(minimum),      64'(e.mn));
                chk("peak_to_peak", 64'(peak_to_peak), 64'(e.p2p));
                chk("in_passband",  64'(in_passband),  64'(e.pb));
            end
        end
    end

    // Cycle 0 is the cycle in which start is high; REPORT is cycle S+W+1.
    // Returns in the IDLE cycle after REPORT.
    task automatic do_run(input bit setref, input win_t v, input bit poke);
        exp_t   e;
        longint mx, mn, s, p;
        mx = longint'($signed(v[0]));
        mn = mx;
        for (int i = 1; i < W; i++) begin
            s = longint'($signed(v[i]));
            if (s > mx) mx = s;
            if (s < mn) mn = s;
        end
        p     = mx - mn;
        e.mx  = mx[DW-1:0];
        e.mn  = mn[DW-1:0];
        e.p2p = p[DW:0];
        e.pb  = setref ? 1'b1 : (p * 181 >= ref_model * 128);
        if (setref) ref_model = p;
        q.push_back(e);

        start = 1'b1; set_reference = setref; data = $urandom;
        for (int c = 1; c <= S + W; c++) begin
            @(negedge clock);
            if (c == 1) chk("busy_after_start", 64'(busy), 64'd1);
            chk("valid_early", 64'(result_valid), 64'd0);
            start         = poke && (c == S + 3);
            set_reference = 1'b0;
            data          = (c <= S) ? $urandom : v[c-S-1];
        end
        @(negedge clock);
        chk("valid_on_time", 64'(result_valid), 64'd1);
        chk("busy_in_report", 64'(busy), 64'd1);
        start = poke;
        data  = $urandom;
        @(negedge clock);
        chk("busy_after_report", 64'(busy), 64'd0);
        chk("valid_single", 64'(result_valid), 64'd0);
        start = 1'b0;
    endtask

    initial begin
        win_t w;
        reset_n = 1'b0; start = 1'b0; set_reference = 1'b0; data = '0;
        start2 = 1'b0; set_ref2 = 1'b0; data2 = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy",  64'(busy),         64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_max",   64'(maximum),      64'd0);
        chk("rst_min",   64'(minimum),      64'd0);
        chk("rst_p2p",   64'(peak_to_peak), 64'd0);
        chk("rst_pb",    64'(in_passband),  64'd0);
        chk("rst_busy2", 64'(busy2),        64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Ramp -100..+100, becomes the reference (200)
        w = '{32'(-100), 32'(-71), 32'(-43), 32'(-14), 32'(14), 32'(43), 32'(71), 32'(100)};
        do_run(1'b1, w, 1'b0);
        // +/-70: 140*181 = 25340 < 25600
        for (int i = 0; i < W; i++) w[i] = (i % 2 == 0) ? 32'(70) : 32'(-70);
        do_run(1'b0, w, 1'b0);
        // +/-71: 142*181 = 25702 >= 25600
        for (int i = 0; i < W; i++) w[i] = (i % 2 == 0) ? 32'(-71) : 32'(71);
        do_run(1'b0, w, 1'b0);
        // Constant data
        for (int i = 0; i < W; i++) w[i] = 32'd37;
        do_run(1'b0, w, 1'b0);
        // Full-scale swing with start pokes in MEASURE and REPORT
        w = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000,
              32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        do_run(1'b1, w, 1'b1);
        // Starts in the IDLE cycle right after REPORT
        for (int i = 0; i < W; i++) w[i] = (i % 2 == 0) ? 32'(50) : 32'(-50);
        do_run(1'b0, w, 1'b0);

        // Abort mid-MEASURE with a reset
        start = 1'b1; set_reference = 1'b1; data = $urandom;
        for (int c = 1; c <= S + 3; c++) begin
            @(negedge clock);
            start = 1'b0; set_reference = 1'b0; data = $urandom;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),         64'd0);
        chk("abort_valid", 64'(result_valid), 64'd0);
        chk("abort_max",   64'(maximum),      64'd0);
        chk("abort_min",   64'(minimum),      64'd0);
        chk("abort_p2p",   64'(peak_to_peak), 64'd0);
        chk("abort_pb",    64'(in_passband),  64'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        ref_model = 0;
        @(negedge clock);

        // Cleared reference: small swing still in passband
        for (int i = 0; i < W; i++) w[i] = (i % 2 == 0) ? 32'(20) : 32'(-20);
        do_run(1'b0, w, 1'b0);

        // Zero settle, one-sample window
        start2 = 1'b1; data2 = 32'h1111_1111;
        @(negedge clock);
        chk("short_valid_early", 64'(valid2), 64'd0);
        chk("short_busy",        64'(busy2),  64'd1);
        start2 = 1'b0; data2 = 32'hDEAD_BEEF;
        @(negedge clock);
        data2 = 32'h0000_0005;
        chk("short_valid", 64'(valid2), 64'd1);
        chk("short_max",   64'(max2),   64'hDEAD_BEEF);
        chk("short_min",   64'(min2),   64'hDEAD_BEEF);
        chk("short_p2p",   64'(p2p2),   64'd0);
        chk("short_pb",    64'(pb2),    64'd1);
        @(negedge clock);
        chk("short_valid_pulse", 64'(valid2), 64'd0);

        repeat (3) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("valid_count",   64'(n_valid),  64'd7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
